// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for MULT/MULTU/DIV/DIVU: drives the external divider and multiplier,
// stalls EX while busy and owns HI/LO. Optional feature macro: MULDIV_DIVZERO_FAST_EN.
module muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_opa,
  input  logic [31:0] ex_opb,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        stall_req,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        mul_valid_in,
  output logic        mul_signed,
  input  logic        mul_valid_out,
  input  logic [63:0] mul_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MULDIV_DIVZERO_FAST_EN
  localparam bit DIVZERO_FAST = 1'b1;
`else
  localparam bit DIVZERO_FAST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, DIV, MUL, DONE, DRAIN} state_t;

  state_t      state;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [3:0]  drain_cnt;
  logic        op_signed;

  logic is_mul, is_div, md_req, launch, div_fast, launch_div, launch_mul;

  always_comb begin
    is_mul     = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
    is_div     = (ex_op == OP_DIV) || (ex_op == OP_DIVU);
    md_req     = resetn && ex_valid && (is_mul || is_div) && !flush;
    launch     = md_req && (state == IDLE);
    div_fast   = DIVZERO_FAST && is_div && (ex_opb == 32'd0);
    launch_div = launch && is_div && !div_fast;
    launch_mul = launch && is_mul;
  end

  // Launch-cycle outputs come straight from EX so the units see the op in the issue cycle.
  always_comb begin
    stall_req    = (state == DIV) || (state == MUL) ||
                   (md_req && ((state == IDLE) || (state == DRAIN)));
    div_start    = launch_div || ((state == DIV) && !flush);
    div_annul    = (state == DIV) && flush;
    div_signed   = launch_div ? (ex_op == OP_DIV) : ((state == DIV) && op_signed);
    mul_valid_in = launch_mul;
    mul_signed   = launch_mul ? (ex_op == OP_MULT) : ((state == MUL) && op_signed);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      hi_o      <= 32'd0;
      lo_o      <= 32'd0;
      res_hi    <= 32'd0;
      res_lo    <= 32'd0;
      drain_cnt <= 4'd0;
      op_signed <= 1'b0;
    end else begin
      // Counts down to the cycle the in-flight product returns, so DRAIN ends on time
      // even when the flush coincided with mul_valid_out.
      if (((state == MUL) || (state == DRAIN)) && (drain_cnt != 4'd0))
        drain_cnt <= drain_cnt - 4'd1;
      case (state)
        IDLE: begin
          if (launch) begin
            op_signed <= (ex_op == OP_MULT) || (ex_op == OP_DIV);
            if (div_fast) begin
              res_hi <= ex_opa;
              res_lo <= 32'hFFFF_FFFF;
              state  <= DONE;
            end else if (is_div) begin
              state <= DIV;
            end else begin
              drain_cnt <= 4'(MUL_LAT - 1);
              state     <= MUL;
            end
          end else if (ex_valid && !flush && !ex_stall) begin
            if (ex_op == OP_MTHI) hi_o <= ex_opa;
            if (ex_op == OP_MTLO) lo_o <= ex_opa;
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else if (div_ready) begin
            {res_hi, res_lo} <= div_result;
            state            <= DONE;
          end
        end
        MUL: begin
          if (flush) begin
            state <= DRAIN;
          end else if (mul_valid_out) begin
            {res_hi, res_lo} <= mul_result;
            state            <= DONE;
          end
        end
        DONE: begin
          if (flush) begin
            state <= IDLE;
          end else if (!ex_stall) begin
            hi_o  <= res_hi;
            lo_o  <= res_lo;
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (mul_valid_out || (drain_cnt == 4'd0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl with behavioural divider/multiplier stubs and an
// architectural HI/LO reference model.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 3;
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_opa;
  logic [31:0] ex_opb;
  logic        ex_stall;
  logic        flush;
  logic        stall_req, div_start, div_signed, div_annul, mul_valid_in, mul_signed;
  logic        div_ready = 1'b0;
  logic [63:0] div_result = 64'd0;
  logic        mul_valid_out;
  logic [63:0] mul_result;
  logic [31:0] hi_o, lo_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          div_lat = 10;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_op(ex_op), .ex_opa(ex_opa),
    .ex_opb(ex_opb), .ex_stall(ex_stall), .flush(flush), .stall_req(stall_req),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_ready(div_ready), .div_result(div_result), .mul_valid_in(mul_valid_in),
    .mul_signed(mul_signed), .mul_valid_out(mul_valid_out), .mul_result(mul_result),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MIPS HI/LO result: products as {hi,lo}; divides as {remainder,quotient}; x/0 gives {x, all-ones}.
  function automatic logic [63:0] arith(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] r, q64, r64;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (op == OP_DIV) begin
          q64 = 64'(sa / sb);
          r64 = 64'(sa % sb);
          r = {r64[31:0], q64[31:0]};
        end else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Iterative divider stub: result div_lat cycles after the start cycle, cancellable by annul.
  logic        dv_busy = 1'b0;
  int          dv_cnt = 0;
  logic [63:0] dv_res = 64'd0;
  always @(posedge clk) begin
    div_ready <= 1'b0;
    if (dv_busy) begin
      if (div_annul) dv_busy <= 1'b0;
      else if (dv_cnt <= 1) begin
        div_ready  <= 1'b1;
        div_result <= dv_res;
        dv_busy    <= 1'b0;
      end else dv_cnt <= dv_cnt - 1;
    end else if (div_start && !div_ready) begin
      dv_busy <= 1'b1;
      dv_cnt  <= div_lat - 1;
      dv_res  <= arith(div_signed ? OP_DIV : OP_DIVU, ex_opa, ex_opb);
    end
  end

  // Pipelined multiplier stub: fixed MUL_LAT, not cancellable, unaffected by reset.
  logic [MUL_LAT:1] mp_v = '0;
  logic [63:0]      mp_d [1:MUL_LAT];
  always @(posedge clk) begin
    mp_v[1] <= mul_valid_in;
    mp_d[1] <= arith(mul_signed ? OP_MULT : OP_MULTU, ex_opa, ex_opb);
    for (int i = 2; i <= MUL_LAT; i++) begin
      mp_v[i] <= mp_v[i-1];
      mp_d[i] <= mp_d[i-1];
    end
  end
  assign mul_valid_out = mp_v[MUL_LAT];
  assign mul_result    = mp_d[MUL_LAT];

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int hold, input int pre);
    int stalls = 0, launches = 0, starts = 0, exp_stalls;
    bit done = 0, sgn_seen = 0, is_div, fast;
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    fast = 0;
`ifdef MULDIV_DIVZERO_FAST_EN
    fast = is_div && (b == 32'd0);
`endif
    exp_stalls = pre + (fast ? 1 : (is_div ? lat + 1 : MUL_LAT + 1));
    div_lat = lat;
    ex_valid = 1'b1; ex_op = op; ex_opa = a; ex_opb = b; ex_stall = 1'b0; flush = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mul_valid_in) launches++;
      if (div_start) starts++;
      if ((mul_valid_in || div_start) && !sgn_seen) begin
        sgn_seen = 1;
        check("launch_sign", 64'({mul_signed, div_signed}),
              64'({op == OP_MULT, op == OP_DIV}));
      end
      if (stall_req) stalls++; else done = 1;
    end
    if (!done) check("done_timeout", 64'(0), 64'(1));
    check("stall_cycles", 64'(stalls), 64'(exp_stalls));
    check("mul_launches", 64'(launches), 64'((is_div) ? 0 : 1));
    check("div_start_cycles", 64'(starts), 64'((is_div && !fast) ? lat + 1 : 0));
    check("pre_commit", {hi_o, lo_o}, {m_hi, m_lo});
    if (hold > 0) begin
      ex_stall = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        check("hold_ctl", 64'({stall_req, mul_valid_in, div_start}), 64'(0));
        check("hold_hilo", {hi_o, lo_o}, {m_hi, m_lo});
      end
      ex_stall = 1'b0;
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = OP_NONE;
    {m_hi, m_lo} = arith(op, a, b);
    check("commit", {hi_o, lo_o}, {m_hi, m_lo});
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a, input bit stl, input bit fl);
    ex_valid = 1'b1; ex_op = op; ex_opa = a; ex_stall = stl; flush = fl;
    @(negedge clk);
    check("mt_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = OP_NONE; ex_stall = 1'b0; flush = 1'b0;
    if (!stl && !fl) begin
      if (op == OP_MTHI) m_hi = a; else m_lo = a;
    end
    check("mt_hilo", {hi_o, lo_o}, {m_hi, m_lo});
  endtask

  // Flush the op during cycle k after its launch cycle.
  task automatic do_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int k);
    bit is_div;
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    div_lat = lat;
    ex_valid = 1'b1; ex_op = op; ex_opa = a; ex_opb = b; ex_stall = 1'b0; flush = 1'b0;
    repeat (k + 1) @(negedge clk);
    flush = 1'b1;
    #1;
    if (is_div) check("annul", 64'({div_annul, div_start}), 64'(2'b10));
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0; ex_op = OP_NONE;
    check("flush_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    if (is_div) begin
      @(negedge clk);
      check("flush_idle", 64'({stall_req, div_start, div_annul}), 64'(0));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_idle_flush(input logic [2:0] op, input logic [31:0] a);
    ex_valid = 1'b1; ex_op = op; ex_opa = a; ex_opb = a; flush = 1'b1;
    @(negedge clk);
    check("idle_flush", 64'({stall_req, mul_valid_in, div_start}), 64'(0));
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = OP_NONE; flush = 1'b0;
    check("idle_flush_hilo", {hi_o, lo_o}, {m_hi, m_lo});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          k, lat, sel;
    resetn = 1'b0; ex_valid = 1'b0; ex_op = OP_NONE; ex_opa = 32'd0; ex_opb = 32'd0;
    ex_stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_ctl", 64'({stall_req, div_start, div_signed, div_annul, mul_valid_in, mul_signed}),
          64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    do_arith(OP_DIVU, 32'd100, 32'd7, 33, 0, 0);
    check("divu_100_7", {hi_o, lo_o}, {32'd2, 32'd14});
    do_arith(OP_MULT, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    check("mult_m1_2", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    do_flush(OP_DIV, 32'd1000, 32'd3, 20, 10);
    do_flush(OP_MULTU, 32'd11, 32'd13, 0, 1);
    do_arith(OP_MULTU, 32'd7, 32'd9, 0, 0, MUL_LAT - 1);
    check("multu_after_drain", {hi_o, lo_o}, {32'd0, 32'd63});
    do_arith(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 4, 0);
    do_mt(OP_MTLO, 32'h1234, 1'b0, 1'b0);
    check("mtlo_b2b", 64'(lo_o), 64'(32'h1234));
    do_arith(OP_DIV, 32'd5, 32'd0, 8, 0, 0);
    check("div_by_zero", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});

    // Reset in the middle of a divide; the late div_ready must be ignored.
    div_lat = 20;
    ex_valid = 1'b1; ex_op = OP_DIV; ex_opa = 32'd77; ex_opb = 32'd4;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_mid_ctl", 64'({stall_req, div_start, div_signed, div_annul, mul_valid_in,
          mul_signed}), 64'(0));
    check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    ex_valid = 1'b0; ex_op = OP_NONE;
    repeat (2) @(posedge clk); #1;
    resetn = 1'b1;
    repeat (30) @(posedge clk); #1;
    check("late_ready_ignored", {31'd0, stall_req, hi_o}, 64'd0);
    check("late_ready_lo", 64'(lo_o), 64'd0);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      lat = $urandom_range(2, 12);
      case (sel)
        0: do_arith($urandom_range(0, 1) ? OP_MULT : OP_MULTU, a, $urandom, 0,
                    $urandom_range(0, 2), 0);
        1: do_arith($urandom_range(0, 1) ? OP_DIV : OP_DIVU, a, b, lat,
                    $urandom_range(0, 2), 0);
        2: do_mt($urandom_range(0, 1) ? OP_MTHI : OP_MTLO, a, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0);
        3: begin
          if (b == 32'd0) b = 32'd3;
          do_flush($urandom_range(0, 1) ? OP_DIV : OP_DIVU, a, b, lat,
                   $urandom_range(1, lat - 1));
        end
        4: begin
          k = $urandom_range(1, MUL_LAT - 1);
          do_flush($urandom_range(0, 1) ? OP_MULT : OP_MULTU, a, b, 0, k);
          op = $urandom_range(0, 1) ? OP_MULT : OP_MULTU;
          do_arith(op, $urandom, $urandom, 0, 0, MUL_LAT - k);
        end
        default: do_idle_flush(3'($urandom_range(1, 4)), a);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
